// File: rtl/inst_sram_responder.sv
// Instruction-SRAM fetch responder: kseg0/kseg1 translation, one fetch outstanding, bus req held until ack.
// Latency accept->valid is 2+k cycles (1 on a last-hit when INST_RESP_LASTHIT_EN is defined); readen outside IDLE/RESP is ignored.
module inst_sram_responder #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] inst_sram_addr,
   input  logic              inst_sram_readen,
   output logic [DATA_W-1:0] inst_sram_rdata,
   output logic              inst_sram_valid,
   output logic              inst_sram_err,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_err
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state, state_nxt;
   logic              accept;
   logic              hit;
   logic [DATA_W-1:0] hit_data;
   logic [ADDR_W-1:0] phys_addr;
   logic              err_q;

   // Top bits 100/101 select kseg0/kseg1; both map onto the low 512 MiB.
   always_comb begin
      phys_addr = inst_sram_addr;
      if (inst_sram_addr[ADDR_W-1 -: 2] == 2'b10) begin
         phys_addr[ADDR_W-1 -: 3] = 3'b000;
      end
      phys_addr[1:0] = 2'b00;
   end

   assign accept = inst_sram_readen && (state == IDLE || state == RESP);

`ifdef INST_RESP_LASTHIT_EN
   logic              lh_vld;
   logic [ADDR_W-1:0] lh_addr;
   logic [DATA_W-1:0] lh_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         lh_vld  <= 1'b0;
         lh_addr <= '0;
         lh_data <= '0;
      end else if (state == BUSY && mem_ack) begin
         lh_vld  <= !mem_err;
         lh_addr <= mem_addr;
         lh_data <= mem_rdata;
      end
   end

   assign hit      = lh_vld && (lh_addr == phys_addr);
   assign hit_data = lh_data;
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif

   always_comb begin
      state_nxt       = state;
      mem_req         = 1'b0;
      inst_sram_valid = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) state_nxt = hit ? RESP : BUSY;
         end
         BUSY: begin
            mem_req = 1'b1;
            if (mem_ack) state_nxt = RESP;
         end
         RESP: begin
            inst_sram_valid = 1'b1;
            if (accept) state_nxt = hit ? RESP : BUSY;
            else        state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign inst_sram_err = inst_sram_valid && err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         mem_addr        <= '0;
         inst_sram_rdata <= '0;
         err_q           <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            mem_addr <= phys_addr;
         end
         if (state == BUSY && mem_ack) begin
            inst_sram_rdata <= mem_err ? '0 : mem_rdata;
            err_q           <= mem_err;
         end else if (accept && hit) begin
            inst_sram_rdata <= hit_data;
            err_q           <= 1'b0;
         end
      end
   end

endmodule
